// File: rtl/key_expansion_128_if.sv
// Request/read bus of the AES-128 key schedule: start/key_in handshake,
// status flags and the indexed round-key read port.
interface key_expansion_128_if;
    logic         start;
    logic [0:127] key_in;
    logic         busy;
    logic         done;
    logic         key_valid;
    logic [3:0]   rd_idx;
    logic [127:0] round_key;

    modport master (
        output start, key_in, rd_idx,
        input  busy, done, key_valid, round_key
    );

    modport slave (
        input  start, key_in, rd_idx,
        output busy, done, key_valid, round_key
    );
endinterface

// File: rtl/key_expansion_128.sv
// Iterative AES-128 key schedule: one 32-bit word per clock into a 44-word
// register file, read back as 128-bit round keys with one-cycle latency.
// Optional macro KEYEXP_REVERSE_IDX_EN mirrors the read index (rd_idx 0 -> rk10).
module key_expansion_128 #(
    parameter int NUM_ROUNDS = 10
) (
    input logic               Clk,
    input logic               Reset_n,
    key_expansion_128_if.slave bus
);
    localparam int NUM_WORDS = 4 * (NUM_ROUNDS + 1);

    // Forward FIPS-197 S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        sbox = SBOX_TABLE[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        rot_word = {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t       state_r;
    state_t       next_state_s;
    logic [31:0]  w_r [0:NUM_WORDS-1];
    logic [5:0]   i_r;
    logic [7:0]   rcon_r;
    logic         busy_r;
    logic         done_r;
    logic         key_valid_r;
    logic [127:0] round_key_r;

    logic [5:0]   prev_idx_s;
    logic [5:0]   back_idx_s;
    logic [31:0]  temp_s;
    logic [31:0]  new_word_s;
    logic         last_word_s;
    logic         idx_ok_s;
    logic [3:0]   sel_idx_s;
    logic [5:0]   base_s;
    logic [127:0] sel_key_s;

    // Next schedule word w[i] from w[i-1] and w[i-4].
    always_comb begin
        prev_idx_s  = i_r - 6'd1;
        back_idx_s  = i_r - 6'd4;
        if (i_r[1:0] == 2'b00) begin
            temp_s = sub_word(rot_word(w_r[prev_idx_s])) ^ {rcon_r, 24'h000000};
        end else begin
            temp_s = w_r[prev_idx_s];
        end
        new_word_s  = w_r[back_idx_s] ^ temp_s;
        last_word_s = (i_r == 6'(NUM_WORDS - 1));
    end

    // Round-key read selection, gated by schedule validity and index range.
    always_comb begin
        idx_ok_s = (bus.rd_idx <= 4'(NUM_ROUNDS));
`ifdef KEYEXP_REVERSE_IDX_EN
        sel_idx_s = 4'(NUM_ROUNDS) - bus.rd_idx;
`else
        sel_idx_s = bus.rd_idx;
`endif
        base_s = {sel_idx_s, 2'b00};
        if (key_valid_r && idx_ok_s) begin
            sel_key_s = {w_r[base_s], w_r[base_s + 6'd1], w_r[base_s + 6'd2], w_r[base_s + 6'd3]};
        end else begin
            sel_key_s = 128'h0;
        end
    end

    // FSM next-state logic; start is only honoured outside EXPAND.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    next_state_s = bus.start ? EXPAND : IDLE;
            EXPAND:  next_state_s = last_word_s ? READY : EXPAND;
            READY:   next_state_s = bus.start ? EXPAND : READY;
            default: next_state_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Key storage, word counter, rcon and status flags.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                w_r[k] <= 32'h0;
            end
            i_r         <= 6'd0;
            rcon_r      <= 8'h01;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            key_valid_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE, READY: begin
                    if (bus.start) begin
                        w_r[0]      <= bus.key_in[0:31];
                        w_r[1]      <= bus.key_in[32:63];
                        w_r[2]      <= bus.key_in[64:95];
                        w_r[3]      <= bus.key_in[96:127];
                        i_r         <= 6'd4;
                        rcon_r      <= 8'h01;
                        key_valid_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                EXPAND: begin
                    w_r[i_r] <= new_word_s;
                    i_r      <= i_r + 6'd1;
                    if (i_r[1:0] == 2'b00) begin
                        rcon_r <= xtime(rcon_r);
                    end else begin
                        rcon_r <= rcon_r;
                    end
                    if (last_word_s) begin
                        busy_r      <= 1'b0;
                        key_valid_r <= 1'b1;
                        done_r      <= 1'b1;
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Registered round-key output.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            round_key_r <= 128'h0;
        end else begin
            round_key_r <= sel_key_s;
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.key_valid = key_valid_r;
    assign bus.round_key = round_key_r;
endmodule

// File: tb/tb_key_expansion_128.sv
// Directed bench for key_expansion_128 using FIPS-197 A.1 and C.1 key vectors.
module tb_key_expansion_128;
    logic Clk = 1'b0;
    logic Reset_n;

    always #5 Clk = ~Clk;

    key_expansion_128_if bus();

    key_expansion_128 dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

    int n_assert = 0;
    int n_fail   = 0;
    logic [127:0] gold_a [0:10];
    logic [127:0] gold_b [0:10];

    function automatic logic [3:0] map_idx(input int k);
`ifdef KEYEXP_REVERSE_IDX_EN
        return 4'(10 - k);
`else
        return 4'(k);
`endif
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        check(tag, {127'd0, obs}, {127'd0, exp});
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_key(input logic [127:0] k);
        bus.key_in = k;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(output int edges, output int busy_cnt);
        busy_cnt = bus.busy ? 1 : 0;
        edges    = -1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                edges = c;
                break;
            end
        end
    endtask

    task automatic read_key(input string tag, input logic [3:0] idx, input logic [127:0] exp);
        bus.rd_idx = idx;
        tick();
        check(tag, bus.round_key, exp);
    endtask

    initial begin
        int edges;
        int busy_cnt;
        logic [127:0] exp_key;

        gold_a[0]  = KEY_A;
        gold_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        gold_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        gold_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        gold_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        gold_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        gold_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        gold_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        gold_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        gold_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
        gold_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int k = 0; k <= 10; k++) gold_b[k] = 128'h0;
        gold_b[0]  = KEY_B;
        gold_b[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        gold_b[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

        Reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.key_in = 128'h0;
        bus.rd_idx = 4'd0;
        #1;
        check_bit("reset_busy", bus.busy, 1'b0);
        check_bit("reset_done", bus.done, 1'b0);
        check_bit("reset_key_valid", bus.key_valid, 1'b0);
        check("reset_round_key", bus.round_key, 128'h0);
        tick();
        tick();
        Reset_n = 1'b1;
        tick();

        // A.1 expansion from IDLE
        start_key(KEY_A);
        check_bit("a1_busy_after_start", bus.busy, 1'b1);
        check_bit("a1_kv_after_start", bus.key_valid, 1'b0);
        wait_done(edges, busy_cnt);
        check("a1_done_latency", 128'(edges), 128'd40);
        check("a1_busy_cycles", 128'(busy_cnt), 128'd40);
        check_bit("a1_busy_at_done", bus.busy, 1'b0);
        check_bit("a1_kv_at_done", bus.key_valid, 1'b1);
        tick();
        check_bit("a1_done_one_cycle", bus.done, 1'b0);
        read_key("a1_rk1", map_idx(1), gold_a[1]);
        read_key("a1_rk10", map_idx(10), gold_a[10]);
        read_key("a1_rk0", map_idx(0), gold_a[0]);

        // Consecutive-cycle index sweep including out-of-range indices
        for (int k = 0; k < 16; k++) begin
            exp_key = (k <= 10) ? gold_a[map_idx(k)] : 128'h0;
            read_key($sformatf("sweep_idx%0d", k), 4'(k), exp_key);
        end

        // Restart from READY, then a start mid-expansion that must be ignored
        bus.rd_idx = map_idx(10);
        start_key(KEY_A);
        check_bit("restart_kv_drop", bus.key_valid, 1'b0);
        tick();
        check("restart_rk_zero", bus.round_key, 128'h0);
        for (int k = 0; k < 8; k++) tick();
        bus.key_in = KEY_B;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        check_bit("ignored_start_busy", bus.busy, 1'b1);
        wait_done(edges, busy_cnt);
        check("ignored_start_latency", 128'(edges), 128'd30);
        read_key("ignored_start_rk10", map_idx(10), gold_a[10]);

        // Asynchronous reset in the middle of an expansion
        start_key(KEY_A);
        for (int k = 0; k < 19; k++) tick();
        #3;
        Reset_n = 1'b0;
        #1;
        check_bit("async_rst_busy", bus.busy, 1'b0);
        check_bit("async_rst_done", bus.done, 1'b0);
        check_bit("async_rst_kv", bus.key_valid, 1'b0);
        check("async_rst_round_key", bus.round_key, 128'h0);
        tick();
        Reset_n = 1'b1;
        tick();
        start_key(KEY_B);
        wait_done(edges, busy_cnt);
        check("keyb_done_latency", 128'(edges), 128'd40);
        read_key("keyb_rk0", map_idx(0), gold_b[0]);
        read_key("keyb_rk1", map_idx(1), gold_b[1]);
        read_key("keyb_rk10", map_idx(10), gold_b[10]);
        read_key("keyb_idx15", 4'd15, 128'h0);

        // New key while READY: old schedule invisible until the new done
        bus.rd_idx = map_idx(1);
        start_key(KEY_A);
        check_bit("newkey_kv_drop", bus.key_valid, 1'b0);
        tick();
        check("newkey_rk_zero", bus.round_key, 128'h0);
        wait_done(edges, busy_cnt);
        check("newkey_latency", 128'(edges), 128'd39);
        check("newkey_rk_zero_at_done", bus.round_key, 128'h0);
        read_key("newkey_rk1", map_idx(1), gold_a[1]);
        read_key("newkey_rk10", map_idx(10), gold_a[10]);
        read_key("newkey_rk4", map_idx(4), gold_a[4]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
